// File: rtl/demux_1ton_stream_pkg.sv
// Shared default constants for the stream selector/demux family, so the
// mux and demux sides agree on word and select widths.
package demux_1ton_stream_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 4;
    localparam int DEF_SELW  = 2;

    localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

endpackage

// File: rtl/demux_slot.sv
// Single-entry output register (data + valid) for one demux channel.
// A load wins over a simultaneous drain, so a channel can pass one word per cycle.
module demux_slot
    import demux_1ton_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1ton_stream.sv
// Registered 1-to-N stream demultiplexer: steers each accepted word by sel
// into one of N single-entry output slots; out-of-range sel words are dropped.
module demux_1ton_stream
    import demux_1ton_stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = DEF_SELW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [SELW-1:0]    sel,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [7:0]         drop_cnt,
    output logic               err
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready;
    // valid never depends on ready, and a raised valid holds with stable data
    // until that transfer.
    logic         in_range;
    logic         ch_ready;
    logic         xfer;
    logic         drop;
    logic [N-1:0] load;

    always_comb begin
        in_range = (32'(sel) < N);
        ch_ready = 1'b0;
        load     = '0;
        for (int k = 0; k < N; k++) begin
            if (32'(sel) == k) begin
                ch_ready = !out_valid[k] || out_ready[k];
            end
        end
        // Out-of-range words are always accepted so they can be discarded.
        in_ready = enable && (!in_range || ch_ready);
        xfer     = in_valid && in_ready;
        for (int k = 0; k < N; k++) begin
            load[k] = xfer && (32'(sel) == k);
        end
        drop = xfer && !in_range;
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 8'd0;
            err      <= 1'b0;
        end else begin
            err <= drop;
            if (drop && drop_cnt != DROP_CNT_MAX) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed bench for demux_1ton_stream: a 4-channel instance for routing,
// back-pressure, pass-through and reset, and a 3-channel instance for drops.
module tb_demux_1ton_stream;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- 4-channel instance ----------------
    logic        en4, vin4, rdy4, err4;
    logic [1:0]  sel4;
    logic [7:0]  din4, dcnt4;
    logic [31:0] dout4;
    logic [3:0]  vout4, ordy4;

    demux_1ton_stream #(.WIDTH(8), .N(4), .SELW(2)) dut4 (
        .clk(clk), .rst(rst), .enable(en4), .sel(sel4), .in_data(din4),
        .in_valid(vin4), .in_ready(rdy4), .out_data(dout4), .out_valid(vout4),
        .out_ready(ordy4), .drop_cnt(dcnt4), .err(err4)
    );

    // ---------------- 3-channel instance ----------------
    logic        en3, vin3, rdy3, err3;
    logic [1:0]  sel3;
    logic [7:0]  din3, dcnt3;
    logic [23:0] dout3;
    logic [2:0]  vout3, ordy3;

    demux_1ton_stream #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
        .clk(clk), .rst(rst), .enable(en3), .sel(sel3), .in_data(din3),
        .in_valid(vin3), .in_ready(rdy3), .out_data(dout3), .out_valid(vout3),
        .out_ready(ordy3), .drop_cnt(dcnt3), .err(err3)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive4(input logic en, input logic [1:0] sel, input logic [7:0] d,
                          input logic v, input logic [3:0] ordy);
        @(negedge clk);
        en4 = en; sel4 = sel; din4 = d; vin4 = v; ordy4 = ordy;
        #1;
    endtask

    task automatic drive3(input logic en, input logic [1:0] sel, input logic [7:0] d,
                          input logic v, input logic [2:0] ordy);
        @(negedge clk);
        en3 = en; sel3 = sel; din3 = d; vin3 = v; ordy3 = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        en;
        logic [1:0]  sel;
        logic [7:0]  data;
        logic        vin;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b1, 2'd2, 8'hA5, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00A50000};
        vecs[1] = '{1'b1, 2'd1, 8'h11, 1'b1, 4'b0000, 1'b1, 4'b0110, 32'h00A51100};
        vecs[2] = '{1'b1, 2'd1, 8'h22, 1'b1, 4'b0000, 1'b0, 4'b0110, 32'h00A51100};
        vecs[3] = '{1'b1, 2'd0, 8'h33, 1'b1, 4'b0000, 1'b1, 4'b0111, 32'h00A51133};
        vecs[4] = '{1'b1, 2'd3, 8'h44, 1'b1, 4'b0000, 1'b1, 4'b1111, 32'h44A51133};
        vecs[5] = '{1'b1, 2'd3, 8'h55, 1'b1, 4'b1000, 1'b1, 4'b1111, 32'h55A51133};
        vecs[6] = '{1'b0, 2'd0, 8'h66, 1'b1, 4'b0000, 1'b0, 4'b1111, 32'h55A51133};
        vecs[7] = '{1'b0, 2'd2, 8'h77, 1'b1, 4'b0110, 1'b0, 4'b1001, 32'h55A51133};
        vecs[8] = '{1'b1, 2'd2, 8'h88, 1'b0, 4'b1001, 1'b1, 4'b0000, 32'h55A51133};
        vecs[9] = '{1'b1, 2'd1, 8'h99, 1'b1, 4'b0000, 1'b1, 4'b0010, 32'h55A59933};

        en4 = 1'b0; sel4 = '0; din4 = '0; vin4 = 1'b0; ordy4 = '0;
        en3 = 1'b0; sel3 = '0; din3 = '0; vin3 = 1'b0; ordy3 = '0;

        // Reset state, in_ready still combinational during reset
        #2;
        check("rst_vout4", 32'(vout4), 32'h0);
        check("rst_dout4", dout4, 32'h0);
        check("rst_dcnt4", 32'(dcnt4), 32'h0);
        check("rst_err4", 32'(err4), 32'h0);
        check("rst_rdy_en0", 32'(rdy4), 32'h0);
        en4 = 1'b1;
        #1;
        check("rst_rdy_en1", 32'(rdy4), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // Table: routing, back-pressure, pass-through, enable gating
        for (int i = 0; i < 10; i++) begin
            drive4(vecs[i].en, vecs[i].sel, vecs[i].data, vecs[i].vin, vecs[i].ordy);
            check($sformatf("vec%0d_rdy", i), 32'(rdy4), 32'(vecs[i].exp_rdy));
            tick();
            check($sformatf("vec%0d_valid", i), 32'(vout4), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), dout4, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), 32'(err4), 32'h0);
        end

        // Channel 3 sustained at one word per cycle while ch1 stays stalled
        for (int i = 0; i < 10; i++) begin
            logic [7:0] w;
            w = 8'(i * 17 + 3);
            drive4(1'b1, 2'd3, w, 1'b1, 4'b1000);
            check($sformatf("pt%0d_rdy", i), 32'(rdy4), 32'h1);
            exp_q.push_back(w);
            tick();
            check($sformatf("pt%0d_valid3", i), 32'(vout4[3]), 32'h1);
            check($sformatf("pt%0d_data3", i), 32'(dout4[31:24]), 32'(exp_q.pop_front()));
            check($sformatf("pt%0d_ch1", i), 32'(dout4[15:8]), 32'h99);
        end
        drive4(1'b1, 2'd0, 8'h00, 1'b0, 4'b1000);
        tick();
        check("pt_drain_valid", 32'(vout4), 32'b0010);

        // Drops on the 3-channel instance
        for (int i = 0; i < 3; i++) begin
            drive3(1'b1, 2'd3, 8'hE0 + 8'(i), 1'b1, 3'b000);
            check($sformatf("drop%0d_rdy", i), 32'(rdy3), 32'h1);
            tick();
            check($sformatf("drop%0d_err", i), 32'(err3), 32'h1);
            check($sformatf("drop%0d_vout", i), 32'(vout3), 32'h0);
        end
        check("drop_cnt3", 32'(dcnt3), 32'd3);
        drive3(1'b0, 2'd3, 8'hEE, 1'b1, 3'b000);
        check("drop_en0_rdy", 32'(rdy3), 32'h0);
        tick();
        check("drop_en0_err", 32'(err3), 32'h0);
        check("drop_en0_cnt", 32'(dcnt3), 32'd3);
        for (int i = 0; i < 300; i++) begin
            drive3(1'b1, 2'd3, 8'(i), 1'b1, 3'b000);
            tick();
            if (err3 !== 1'b1 || vout3 !== 3'b000) begin
                check($sformatf("drop_loop%0d", i), {28'h0, vout3, err3}, 32'h1);
            end
        end
        check("drop_loop_err", 32'(err3), 32'h1);
        check("drop_sat", 32'(dcnt3), 32'd255);
        drive3(1'b1, 2'd2, 8'h5A, 1'b1, 3'b000);
        check("n3_ch2_rdy", 32'(rdy3), 32'h1);
        tick();
        check("n3_ch2_valid", 32'(vout3), 32'b100);
        check("n3_ch2_data", 32'(dout3[23:16]), 32'h5A);
        check("n3_ch2_err", 32'(err3), 32'h0);
        check("n3_ch2_cnt", 32'(dcnt3), 32'd255);

        // Fill every slot, then reset asynchronously between clock edges
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 2'(k), 8'hC0 + 8'(k), 1'b1, 4'b0000);
            tick();
        end
        check("fill_valid", 32'(vout4), 32'hF);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_vout4", 32'(vout4), 32'h0);
        check("mid_rst_dout4", dout4, 32'h0);
        check("mid_rst_vout3", 32'(vout3), 32'h0);
        check("mid_rst_dcnt3", 32'(dcnt3), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        en4 = 1'b1; vin4 = 1'b0;
        #1;
        check("post_rst_rdy", 32'(rdy4), 32'h1);
        tick();
        check("post_rst_vout4", 32'(vout4), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
